// File: rtl/out_display_pkg.sv
// out_display_pkg
// Shared constants for the output-display peripheral: the active-low
// seven-segment patterns for each hex digit, the blank/none patterns used
// while the display is idle, and the digit that carries the decimal point.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package out_display_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // All segments dark / no digit enabled.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_NONE   = 8'hFF;

    // The decimal point on this digit separates val1 (left) from val2 (right).
    localparam logic [2:0] DP_DIGIT = 3'd4;

endpackage

// File: rtl/out_display_if.sv
// out_display_if
// The processor's OUT-instruction port as seen by output peripherals.
//   outdisplay : one-cycle write strobe per OUT instruction
//   outsel     : target slot index
//   outval1    : value for the left four digits
//   outval2    : value for the right four digits
// The processor side uses the master modport, peripherals use slave.
interface out_display_if;

    logic        outdisplay;
    logic [2:0]  outsel;
    logic [15:0] outval1;
    logic [15:0] outval2;

    modport master (
        output outdisplay,
        output outsel,
        output outval1,
        output outval2
    );

    modport slave (
        input outdisplay,
        input outsel,
        input outval1,
        input outval2
    );

endinterface

// File: rtl/out_display_hex7seg.sv
// hex7seg
// Combinational hex-digit to seven-segment decoder, active-low outputs.
//   nibble : 4-bit value to show
//   seg_n  : segments {g,f,e,d,c,b,a}, 0 = lit
// Kept standalone so other board peripherals can reuse it.
module hex7seg
    import out_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (nibble)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/out_display.sv
// out_display
// Holds eight 32-bit display slots written by the processor's OUT port and
// scans one of them, chosen by view_sel, onto an 8-digit common-anode
// seven-segment display.
//   clock    : system clock, all state on posedge
//   reset    : synchronous, active-high
//   bus      : OUT-instruction port (slave side)
//   view_sel : slot currently shown
//   an_n     : digit enables, active-low, bit 0 = rightmost digit
//   seg_n    : segments {g..a}, active-low
//   dp_n     : decimal point, active-low
//   updated  : per-slot "written since last viewed" flags
module out_display
    import out_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic             clock,
    input  logic             reset,
    out_display_if.slave     bus,
    input  logic [2:0]       view_sel,
    output logic [7:0]       an_n,
    output logic [6:0]       seg_n,
    output logic             dp_n,
    output logic [7:0]       updated
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [2:0]       dig;
    logic [2:0]       dig_next;
    logic             tick;
    logic [31:0]      slots [8];
    logic [31:0]      view_word;
    logic [3:0]       nibble;
    logic [6:0]       seg_pattern;
    logic [7:0]       updated_next;

    assign tick      = (pre == PRE_LAST);
    assign dig_next  = dig + 3'd1;
    assign view_word = slots[view_sel];

    // Digit d shows bits [4d+3:4d] of {val1,val2}, so digits 0-3 are val2
    // and digits 4-7 are val1. The nibble is read before this edge's write,
    // so a write landing on a tick shows up one tick later.
    assign nibble = view_word[{dig_next, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg_n  (seg_pattern)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                slots[i] <= '0;
            end
        end else if (bus.outdisplay) begin
            slots[bus.outsel] <= {bus.outval1, bus.outval2};
        end
    end

    // Clearing the viewed slot after setting means a write to the slot on
    // screen never raises its own flag.
    always_comb begin
        updated_next = updated;
        if (bus.outdisplay && (bus.outsel != view_sel)) begin
            updated_next[bus.outsel] = 1'b1;
        end
        updated_next[view_sel] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            updated <= '0;
        end else begin
            updated <= updated_next;
        end
    end

    // dig resets to 7 so the first tick after reset lands on digit 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre   <= '0;
            dig   <= 3'd7;
            an_n  <= AN_NONE;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else if (tick) begin
            pre   <= '0;
            dig   <= dig_next;
            an_n  <= ~(8'd1 << dig_next);
            seg_n <= seg_pattern;
            dp_n  <= (dig_next != DP_DIGIT);
        end else begin
            pre   <= pre + PRE_W'(1);
        end
    end

endmodule

// File: tb/tb_out_display.sv
// tb_out_display
// Self-checking bench for out_display with SCAN_DIV=4. A cycle-counting
// reference model predicts every output from the slot contents; a compare
// process checks the DUT against it each cycle, and directed scenarios pin
// the model with hand-computed segment patterns before a random phase.
module tb_out_display;

    localparam int DIV = 4;

    logic       clock;
    logic       reset;
    logic [2:0] view_sel;
    logic [7:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [7:0] updated;

    int checks;
    int failures;

    out_display_if bus ();

    out_display #(.SCAN_DIV(DIV)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .view_sel (view_sel),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .updated  (updated)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: m_n counts edges since reset; every DIV-th edge is a
    // tick showing digit (m_n/DIV - 1) mod 8 of the viewed slot.
    bit          m_valid = 1'b0;
    int          m_n;
    logic [31:0] m_slot [8];
    logic [7:0]  m_upd;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    always @(posedge clock) begin
        int d;
        logic [31:0] word;
        if (reset) begin
            m_valid = 1'b1;
            m_n     = 0;
            for (int i = 0; i < 8; i++) m_slot[i] = '0;
            m_upd   = '0;
            e_an    = 8'hFF;
            e_seg   = 7'h7F;
            e_dp    = 1'b1;
        end else if (m_valid) begin
            m_n = m_n + 1;
            if (m_n % DIV == 0) begin
                d     = ((m_n / DIV) - 1) % 8;
                word  = m_slot[view_sel];
                e_an  = ~(8'd1 << d);
                e_seg = hex_tab[4'((word >> (4 * d)) & 32'hF)];
                e_dp  = (d != 4);
            end
            if (bus.outdisplay) begin
                m_slot[bus.outsel] = {bus.outval1, bus.outval2};
                if (bus.outsel != view_sel) m_upd[bus.outsel] = 1'b1;
            end
            m_upd[view_sel] = 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            check_output("model_an_n", 32'(an_n), 32'(e_an));
            check_output("model_seg_n", 32'(seg_n), 32'(e_seg));
            check_output("model_dp_n", 32'(dp_n), 32'(e_dp));
            check_output("model_updated", 32'(updated), 32'(m_upd));
        end
    end

    // One OUT write: starts just after a negedge, holds for one posedge.
    task automatic apply_stimulus(input logic [2:0] sel, input logic [15:0] v1,
                                  input logic [15:0] v2);
        bus.outdisplay = 1'b1;
        bus.outsel     = sel;
        bus.outval1    = v1;
        bus.outval2    = v2;
        @(negedge clock);
        bus.outdisplay = 1'b0;
    endtask

    function automatic bit model_on_digit(input int d);
        return (m_n >= DIV) && (m_n % DIV == 0) && ((((m_n / DIV) - 1) % 8) == d);
    endfunction

    // Waits for a fresh tick that shows digit d (d < 0: any digit).
    task automatic wait_digit(input int d);
        int budget;
        budget = 200;
        do begin
            @(negedge clock);
            budget--;
        end while (!((d < 0) ? (m_n >= DIV && m_n % DIV == 0) : model_on_digit(d))
                   && budget > 0);
        if (budget == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_digit_%0d timeout", d);
        end
    endtask

    logic [7:0] wrap_seq [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF,
                                 8'hBF, 8'h7F, 8'hFE};

    initial begin
        int budget;
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        view_sel       = 3'd0;
        bus.outdisplay = 1'b0;
        bus.outsel     = 3'd0;
        bus.outval1    = 16'h0;
        bus.outval2    = 16'h0;

        // Reset held two cycles, display blank until the first tick.
        repeat (2) @(negedge clock);
        check_output("rst_an_n", 32'(an_n), 32'hFF);
        check_output("rst_seg_n", 32'(seg_n), 32'h7F);
        check_output("rst_dp_n", 32'(dp_n), 32'h1);
        check_output("rst_updated", 32'(updated), 32'h00);
        reset = 1'b0;
        repeat (DIV - 1) @(negedge clock);
        check_output("pre_tick_an_n", 32'(an_n), 32'hFF);
        @(negedge clock);
        check_output("first_tick_an_n", 32'(an_n), 32'hFE);
        check_output("first_tick_seg_n", 32'(seg_n), 32'(7'b1000000));

        // Write to the slot being viewed.
        view_sel = 3'd3;
        apply_stimulus(3'd3, 16'h1234, 16'hABCD);
        wait_digit(0);
        check_output("view_dig0_d", 32'(seg_n), 32'(7'b0100001));
        wait_digit(3);
        check_output("view_dig3_A", 32'(seg_n), 32'(7'b0001000));
        wait_digit(4);
        check_output("view_dig4_4", 32'(seg_n), 32'(7'b0011001));
        check_output("view_dig4_dp", 32'(dp_n), 32'h0);
        wait_digit(7);
        check_output("view_dig7_1", 32'(seg_n), 32'(7'b1111001));
        check_output("view_upd3", 32'(updated[3]), 32'h0);

        // Background write raises a flag; viewing clears it.
        apply_stimulus(3'd5, 16'h00FF, 16'h0001);
        check_output("bg_updated", 32'(updated), 32'h20);
        view_sel = 3'd5;
        @(negedge clock);
        check_output("bg_view_clear", 32'(updated), 32'h00);
        wait_digit(0);
        check_output("bg_dig0_1", 32'(seg_n), 32'(7'b1111001));
        wait_digit(4);
        check_output("bg_dig4_F", 32'(seg_n), 32'(7'b0001110));

        // Back-to-back writes: last one wins.
        view_sel = 3'd2;
        apply_stimulus(3'd2, 16'h1111, 16'h0000);
        apply_stimulus(3'd2, 16'h2222, 16'h0000);
        apply_stimulus(3'd2, 16'h3333, 16'h0000);
        wait_digit(4);
        check_output("b2b_dig4_3", 32'(seg_n), 32'(7'b0110000));
        wait_digit(0);
        check_output("b2b_dig0_0", 32'(seg_n), 32'(7'b1000000));

        // Reset mid-scan blanks at once and clears the slot.
        view_sel = 3'd3;
        apply_stimulus(3'd3, 16'h5555, 16'h5555);
        wait_digit(5);
        reset = 1'b1;
        @(negedge clock);
        check_output("midrst_an_n", 32'(an_n), 32'hFF);
        check_output("midrst_seg_n", 32'(seg_n), 32'h7F);
        reset = 1'b0;
        wait_digit(0);
        check_output("midrst_dig0", 32'(seg_n), 32'(7'b1000000));
        wait_digit(5);
        check_output("midrst_dig5", 32'(seg_n), 32'(7'b1000000));

        // Digit wrap across nine ticks.
        wait_digit(0);
        check_output("wrap_0", 32'(an_n), 32'(wrap_seq[0]));
        for (int k = 1; k < 9; k++) begin
            wait_digit(-1);
            check_output($sformatf("wrap_%0d", k), 32'(an_n), 32'(wrap_seq[k]));
        end

        // Write landing on a tick: old nibble now, new nibble next tick.
        view_sel = 3'd1;
        budget = 50;
        @(negedge clock);
        while (((m_n + 1) % DIV != 0) && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check_output("collide_align", 32'(budget > 0), 32'h1);
        apply_stimulus(3'd1, 16'hFFFF, 16'hFFFF);
        check_output("collide_old", 32'(seg_n), 32'(7'b1000000));
        wait_digit(-1);
        check_output("collide_new", 32'(seg_n), 32'(7'b0001110));

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            bus.outdisplay = ($urandom_range(2) == 0);
            bus.outsel     = 3'($urandom_range(7));
            bus.outval1    = 16'($urandom);
            bus.outval2    = 16'($urandom);
            if ($urandom_range(15) == 0) view_sel = 3'($urandom_range(7));
            reset = ($urandom_range(299) == 0);
            @(negedge clock);
        end
        bus.outdisplay = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
